// File: rtl/cm_topk_pkg.sv
// Shared types for the top-K sorted CAM: table entry layout, readout FSM states and default sizes.
package cm_topk_pkg;

    localparam int CAM_NUM_ENTRY = 16;
    localparam int CAM_ADDR_SIZE = 22;
    localparam int CAM_CNT_SIZE  = 18;
    localparam int CAM_DROP_SIZE = 16;

    typedef struct packed {
        logic                     valid;
        logic [CAM_ADDR_SIZE-1:0] addr;
        logic [CAM_CNT_SIZE-1:0]  cnt;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        READOUT = 2'd2,
        CLEAR   = 2'd3
    } state_e;

endpackage

// File: rtl/topk_insert_pos.sv
// Combinational lookup over the sorted table: address match vector, hit index,
// insertion position for the incoming count, and table-full flag.
module topk_insert_pos
    import cm_topk_pkg::*;
#(
    parameter int NUM_ENTRY = CAM_NUM_ENTRY,
    parameter int IW        = $clog2(NUM_ENTRY),
    parameter int PW        = $clog2(NUM_ENTRY + 1)
) (
    input  entry_t                   table_i [NUM_ENTRY],
    input  logic [CAM_ADDR_SIZE-1:0] addr_i,
    input  logic [CAM_CNT_SIZE-1:0]  cnt_i,
    output logic [NUM_ENTRY-1:0]     match_o,
    output logic [IW-1:0]            hit_idx_o,
    output logic [PW-1:0]            pos_o,
    output logic                     full_o
);

    logic [NUM_ENTRY-1:0] match;

    always_comb begin
        match     = '0;
        hit_idx_o = '0;
        pos_o     = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            match[i] = table_i[i].valid && (table_i[i].addr == addr_i);
        end
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (match[i]) hit_idx_o = IW'(i);
        end
        // The hit entry is being moved, so it does not count toward its own new slot.
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (table_i[i].valid && !match[i] && (table_i[i].cnt >= cnt_i)) begin
                pos_o = pos_o + 1'b1;
            end
        end
    end

    assign match_o = match;
    assign full_o  = table_i[NUM_ENTRY-1].valid;

endmodule

// File: rtl/topk_sorted_cam.sv
// Keeps the NUM_ENTRY hottest addresses from the sketch estimate stream in a
// count-descending table; a query streams the table out and then clears it.
module topk_sorted_cam
    import cm_topk_pkg::*;
#(
    parameter  int NUM_ENTRY = CAM_NUM_ENTRY,
    parameter  int DROP_SIZE = CAM_DROP_SIZE,
    localparam int ADDR_SIZE = CAM_ADDR_SIZE,
    localparam int CNT_SIZE  = CAM_CNT_SIZE,
    localparam int IW        = $clog2(NUM_ENTRY),
    localparam int PW        = $clog2(NUM_ENTRY + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ADDR_SIZE-1:0] in_addr,
    input  logic [CNT_SIZE-1:0]  in_cnt,
    input  logic                 query_en,
    // Readout: a beat transfers on a cycle with out_valid & out_ready; while
    // out_valid is high and out_ready is low, out_* stay unchanged.
    output logic                 out_valid,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic [CNT_SIZE-1:0]  out_cnt,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [DROP_SIZE-1:0] drop_cnt,
    output state_e               dbg_state
);

    state_e               state_q, state_d;
    logic                 drain_q, drain_d;
    logic [IW-1:0]        k_q, k_d, k_next;
    entry_t               table_q [NUM_ENTRY];
    entry_t               table_d [NUM_ENTRY];
    entry_t               rem     [NUM_ENTRY];
    entry_t               ins;
    logic                 s0_valid_q;
    logic [ADDR_SIZE-1:0] s0_addr_q;
    logic [CNT_SIZE-1:0]  s0_cnt_q;
    logic [DROP_SIZE-1:0] drop_q;
    logic [NUM_ENTRY-1:0] match;
    logic [IW-1:0]        hit_idx;
    logic [PW-1:0]        pos;
    logic                 hit, full, do_write, last_beat, accept;

    topk_insert_pos #(.NUM_ENTRY(NUM_ENTRY), .IW(IW), .PW(PW)) u_insert_pos (
        .table_i   (table_q),
        .addr_i    (s0_addr_q),
        .cnt_i     (s0_cnt_q),
        .match_o   (match),
        .hit_idx_o (hit_idx),
        .pos_o     (pos),
        .full_o    (full)
    );

    assign hit    = |match;
    assign k_next = k_q + 1'b1;
    // New samples enter only in IDLE, so the table is frozen before readout starts.
    assign accept = in_valid && (state_q == IDLE);

    always_comb begin
        last_beat = 1'b1;
        if (k_q != IW'(NUM_ENTRY - 1)) last_beat = !table_q[k_next].valid;
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (query_en) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    k_d     = '0;
                    state_d = table_q[0].valid ? READOUT : CLEAR;
                end
            end
            READOUT: begin
                if (out_ready) begin
                    if (last_beat) state_d = CLEAR;
                    else           k_d     = k_next;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Remove the hit entry (if any), then insert the sample at pos; on a full
    // miss the tail entry simply falls off the end of the shift.
    always_comb begin
        ins      = {1'b1, s0_addr_q, s0_cnt_q};
        do_write = s0_valid_q && (hit || !full || (s0_cnt_q > table_q[NUM_ENTRY-1].cnt));
        for (int j = 0; j < NUM_ENTRY; j++) begin
            rem[j] = table_q[j];
            if (hit && (IW'(j) >= hit_idx)) begin
                rem[j] = table_q[(j < NUM_ENTRY - 1) ? j + 1 : j];
                if (j == NUM_ENTRY - 1) rem[j] = '0;
            end
        end
        for (int i = 0; i < NUM_ENTRY; i++) begin
            table_d[i] = table_q[i];
            if (state_q == CLEAR) begin
                table_d[i] = '0;
            end else if (do_write) begin
                if (PW'(i) < pos)       table_d[i] = rem[i];
                else if (PW'(i) == pos) table_d[i] = ins;
                else                    table_d[i] = rem[(i > 0) ? i - 1 : 0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            k_q        <= '0;
            s0_valid_q <= 1'b0;
            s0_addr_q  <= '0;
            s0_cnt_q   <= '0;
            drop_q     <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) table_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            k_q        <= k_d;
            s0_valid_q <= accept;
            if (accept) begin
                s0_addr_q <= in_addr;
                s0_cnt_q  <= in_cnt;
            end
            if (in_valid && busy && !(&drop_q)) drop_q <= drop_q + 1'b1;
            for (int i = 0; i < NUM_ENTRY; i++) table_q[i] <= table_d[i];
        end
    end

    assign busy      = (state_q == READOUT) || (state_q == CLEAR);
    assign out_valid = (state_q == READOUT);
    assign out_addr  = out_valid ? table_q[k_q].addr : '0;
    assign out_cnt   = out_valid ? table_q[k_q].cnt  : '0;
    assign out_last  = out_valid && last_beat;
    assign drop_cnt  = drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_topk_sorted_cam.sv
// Bench for topk_sorted_cam: a queue-based reference model produces the expected
// readout order; a negedge monitor pops and compares each accepted beat.
module tb_topk_sorted_cam;
    import cm_topk_pkg::*;

    localparam int AW = CAM_ADDR_SIZE;
    localparam int CW = CAM_CNT_SIZE;
    localparam int N  = CAM_NUM_ENTRY;
    localparam int BW = AW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [CW-1:0] in_cnt = '0;
    logic          query_en = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid, out_last, busy;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] out_cnt;
    logic [15:0]   drop_cnt;
    state_e        dbg_state;

    int            n_checks = 0;
    int            n_fail = 0;
    int            beats = 0;
    int            busy_cyc = 0;
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] m_addr[$];
    logic [CW-1:0] m_cnt[$];
    logic [15:0]   drop_exp = '0;
    logic [BW:0]   snap;

    always #5 clk = ~clk;

    topk_sorted_cam dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_cnt    (in_cnt),
        .query_en  (query_en),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_cnt   (out_cnt),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() > 0) check("beat", {out_addr, out_cnt, out_last}, exp_q.pop_front());
        end
    end

    task automatic model_sample(input logic [AW-1:0] a, input logic [CW-1:0] c);
        int h;
        int p;
        h = -1;
        p = 0;
        for (int i = 0; i < m_addr.size(); i++) if (m_addr[i] == a) h = i;
        if (h >= 0) begin
            m_addr.delete(h);
            m_cnt.delete(h);
        end else if (m_addr.size() == N) begin
            if (c <= m_cnt[N-1]) return;
            void'(m_addr.pop_back());
            void'(m_cnt.pop_back());
        end
        while (p < m_cnt.size() && m_cnt[p] >= c) p++;
        m_addr.insert(p, a);
        m_cnt.insert(p, c);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_addr  = a;
        in_cnt   = c;
        model_sample(a, c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic start_query();
        int n;
        beats    = 0;
        busy_cyc = 0;
        n = m_addr.size();
        for (int i = 0; i < n; i++) exp_q.push_back({m_addr[i], m_cnt[i], (i == n - 1)});
        m_addr.delete();
        m_cnt.delete();
        query_en = 1'b1;
        @(posedge clk);
        #1;
        query_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (dbg_state != IDLE && n < budget) begin
            @(negedge clk);
            busy_cyc += int'(busy);
            n++;
        end
        check({tag, "_idle"}, 64'(dbg_state == IDLE), 64'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic feed_if_busy();
        if (busy) begin
            in_valid = 1'b1;
            in_addr  = AW'(32'h200000 + $urandom_range(0, 255));
            in_cnt   = CW'($urandom_range(1, 1000));
            if (drop_exp != 16'hFFFF) drop_exp++;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // Ascending fill: each new sample lands at the head.
        for (int i = 1; i <= N; i++) send(AW'(i), CW'(i));
        start_query();
        wait_idle(100, "fill");
        check("fill_beats", 64'(beats), 64'd16);
        check("fill_left", 64'(exp_q.size()), 64'd0);
        start_query();
        wait_idle(20, "fill_empty");
        check("fill_empty_beats", 64'(beats), 64'd0);

        // Eviction of the tail and discard of a too-small miss.
        for (int i = 0; i < N; i++) send(AW'(32'h100 + i), CW'(10 + i));
        send(AW'(32'h3FFFF0), CW'(11));
        send(AW'(32'h3FFFF1), CW'(9));
        start_query();
        wait_idle(100, "evict");
        check("evict_beats", 64'(beats), 64'd16);
        check("evict_drop", 64'(drop_cnt), 64'(drop_exp));

        // Back-to-back hit that moves A ahead of B.
        send(AW'(32'hA), CW'(5));
        send(AW'(32'hB), CW'(7));
        send(AW'(32'hA), CW'(9));
        start_query();
        wait_idle(40, "hit");
        check("hit_beats", 64'(beats), 64'd2);

        // Readout backpressure with samples arriving while busy.
        send(AW'(32'h11), CW'(30));
        send(AW'(32'h22), CW'(20));
        send(AW'(32'h33), CW'(25));
        out_ready = 1'b0;
        start_query();
        wait_out_valid("bp");
        snap = {out_valid, out_addr, out_cnt, out_last};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            feed_if_busy();
            @(negedge clk);
            check("bp_hold", 64'({out_valid, out_addr, out_cnt, out_last}), 64'(snap));
        end
        n = 0;
        while (dbg_state != IDLE && n < 40) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
            feed_if_busy();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_idle", 64'(dbg_state == IDLE), 64'd1);
        check("bp_beats", 64'(beats), 64'd3);
        @(negedge clk);
        check("bp_drop", 64'(drop_cnt), 64'(drop_exp));

        // Empty query: no beats, busy only during CLEAR.
        start_query();
        wait_idle(20, "empty");
        check("empty_beats", 64'(beats), 64'd0);
        check("empty_busy_cycles", 64'(busy_cyc), 64'd1);

        // Reset while beat 2 is on the port.
        send(AW'(32'h44), CW'(8));
        send(AW'(32'h45), CW'(6));
        send(AW'(32'h46), CW'(4));
        start_query();
        wait_out_valid("rr");
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_out_valid", 64'(out_valid), 64'd0);
        check("rr_out_data", 64'({out_addr, out_cnt, out_last}), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_drop", 64'(drop_cnt), 64'd0);
        check("rr_beats", 64'(beats), 64'd1);
        exp_q.delete();
        drop_exp  = '0;
        out_ready = 1'b1;
        start_query();
        wait_idle(20, "rr_after");
        check("rr_after_beats", 64'(beats), 64'd0);

        // Long stall: drop counter saturates.
        send(AW'(32'h55), CW'(3));
        out_ready = 1'b0;
        start_query();
        wait_out_valid("sat");
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #1;
            feed_if_busy();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_drop", 64'(drop_cnt), 64'(drop_exp));
        check("sat_drop_ones", 64'(drop_cnt), 64'hFFFF);
        out_ready = 1'b1;
        wait_idle(20, "sat");
        check("sat_beats", 64'(beats), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
